memory: RTL
===========

# memory

Memory-access pipeline stage of the in-order RV32 core, between execute and writeback. Issues loads and stores to the data bus with a valid/ready handshake, stalls upstream while a transfer is outstanding, and formats load data by size and sign. Detects misaligned accesses and forwards exceptions. Registers everything writeback consumes; flushes on a trap without abandoning an in-flight bus transfer.

## Interface
- No parameters; encodings come from `params.vh`.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `pc_in`, `next_pc_in` in 32: instruction PC and successor PC.
- `alu_data_in`, `csr_data_in` in 32: ALU result (also the load/store address), CSR read value.
- `store_data` in 32: rs2 value for stores.
- `load`, `store` in 1: access request; both set never occurs.
- `size` in 2: 00 byte, 01 half, 10 word (11 treated as word).
- `load_signed` in 1: sign-extend loads.
- `write_select_in` in 2, `rd_addr_in` in 5, `csr_addr_in` in 12, `mret_in`, `wfi_in` in 1: writeback control, passed through.
- `valid_in`, `exception_in` in 1, `ecause_in` in 4: upstream status.
- `flush` in 1: trap taken by writeback this cycle.
- `stall` out 1: upstream must hold its registers.
- `mem_valid` out 1, `mem_ready` in 1, `mem_address` out 32 (word-aligned), `mem_store` out 1, `mem_byte_mask` out 4, `mem_store_data` out 32, `mem_load_data` in 32: data bus.
- `pc`, `next_pc`, `alu_data`, `csr_data`, `load_data` out 32; `write_select` out 2; `rd_addr` out 5; `csr_addr` out 12; `mret`, `wfi`, `valid`, `exception` out 1; `ecause` out 4: registered to writeback.

## Operation
- Request is `valid_in && (load || store) && !exception_in`.
- Misaligned means half with `addr[0]`=1, or word with `addr[1:0]`≠0.
- A misaligned request causes no bus access. The instruction passes with `exception`=1 and `ecause` = 4 (load) or 6 (store), in a single cycle.
- Incoming `exception_in` passes through unchanged and suppresses access.
- State machine:
  - IDLE: on an aligned request with no `flush`, latch the bus registers, go to BUSY, output a bubble.
  - BUSY: on `mem_ready`, capture formatted `load_data`, advance the instruction to writeback, go to IDLE. On `flush` without `mem_ready`, go to DRAIN.
  - DRAIN: wait for `mem_ready`, discard the data, output bubbles, go to IDLE.
- `flush && mem_ready` in BUSY: result discarded, go to IDLE.
- Store: `mem_store_data` is the size-replicated low data (byte ×4, half ×2). Mask is byte `0001<<a[1:0]`, half `0011<<a[1]*2`, word `1111`.
- Load: select the lane by `a[1:0]`, then sign- or zero-extend to 32 bits.
- Non-access instructions pass through in one cycle.
- `flush` has priority: the output register takes a bubble (`valid`=0, `exception`=0, `rd_addr`=0).

## Timing
- Reset values: state IDLE; `mem_valid`, `mem_store` 0; `mem_address`, `mem_store_data`, `mem_byte_mask` 0; all writeback outputs 0.
- `stall` is combinational:
  - IDLE: request && aligned && !`flush`.
  - BUSY: `!mem_ready && !flush`.
  - DRAIN: `!mem_ready` when a request is present, else 0.
- `mem_valid` is registered and rises the cycle after the request is seen.
- While `mem_valid`=1, address, mask, data and `mem_store` are stable until `mem_ready`.
- `mem_valid` drops the cycle after `mem_ready`. A transfer is never withdrawn, including across `flush` and DRAIN.
- Minimum access latency is 2 cycles from the request to `valid` at writeback. Each wait cycle adds one.
- Non-access and exception instructions take 1 cycle.
- `reset` low mid-transfer forces IDLE; the bus slave is reset in the same domain.

## Structure
- `params.vh` holds: `WRITE_SEL_*`, size encodings, ecause constants (4 load misaligned, 6 store misaligned), and state encodings.
- Sub-module `mem_align` (combinational): mask, store-lane replication, load lane select and extend. Unit-tested separately.

## Test plan
- LW at 0x100, `mem_ready` one cycle after `mem_valid`, bus returns 0xDEADBEEF -> `stall` high for 2 cycles, then `load_data`=0xDEADBEEF, `valid`=1.
- LB signed at 0x103, bus 0x80FF_FF7F -> `load_data`=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x202 with data 0x1234ABCD -> `mem_byte_mask`=1100, `mem_store_data`=0xABCDABCD, `mem_address`=0x200.
- LW at 0x101 -> no `mem_valid`, next cycle `exception`=1 with `ecause`=4. SW at 0x102 -> `ecause`=6.
- `flush` on the second BUSY cycle, `mem_ready` 3 cycles later -> `mem_valid` held until ready, no `valid` output, state returns to IDLE.
- `reset` low during BUSY -> next cycle `mem_valid`=0, all outputs 0, state IDLE.

Source files
------------

// File: rtl/memory_pkg.sv
// -----------------------------------------------------------------------------
// memory_pkg
// Shared encodings for the memory-access stage: write-back source selects,
// access sizes, misaligned-access exception causes, FSM states, the
// write-back register bundle and a misalignment helper.
// -----------------------------------------------------------------------------
package memory_pkg;

   // Write-back source selects (consumed by the writeback stage)
   localparam logic [1:0] WRITE_SEL_ALU  = 2'b00;
   localparam logic [1:0] WRITE_SEL_CSR  = 2'b01;
   localparam logic [1:0] WRITE_SEL_LOAD = 2'b10;
   localparam logic [1:0] WRITE_SEL_PC   = 2'b11;

   // Access sizes; 2'b11 behaves as a word
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // Exception causes raised by this stage
   localparam logic [3:0] ECAUSE_LOAD_MISALIGNED  = 4'd4;
   localparam logic [3:0] ECAUSE_STORE_MISALIGNED = 4'd6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_BUSY  = 2'b01,
      ST_DRAIN = 2'b10
   } state_t;

   // Everything handed to writeback, registered as one bundle
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] next_pc;
      logic [31:0] alu_data;
      logic [31:0] csr_data;
      logic [31:0] load_data;
      logic [1:0]  write_select;
      logic [4:0]  rd_addr;
      logic [11:0] csr_addr;
      logic        mret;
      logic        wfi;
      logic        valid;
      logic        exception;
      logic [3:0]  ecause;
   } wb_t;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SIZE_BYTE: is_misaligned = 1'b0;
         SIZE_HALF: is_misaligned = addr_lo[0];
         default:   is_misaligned = (addr_lo != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/memory_if.sv
// -----------------------------------------------------------------------------
// memory_if
// Data-bus handshake between the memory stage (master) and the data memory
// (slave). A transfer is offered with mem_valid and completes in the cycle
// the slave raises mem_ready; request fields hold steady until then.
//   mem_valid      master->slave  transfer pending
//   mem_ready      slave->master  transfer completes this cycle
//   mem_address    master->slave  word-aligned byte address
//   mem_store      master->slave  1 = write, 0 = read
//   mem_byte_mask  master->slave  active byte lanes
//   mem_store_data master->slave  lane-replicated write data
//   mem_load_data  slave->master  read word, valid with mem_ready
// -----------------------------------------------------------------------------
interface memory_if;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_address;
   logic        mem_store;
   logic [3:0]  mem_byte_mask;
   logic [31:0] mem_store_data;
   logic [31:0] mem_load_data;

   modport master (
      output mem_valid, mem_address, mem_store, mem_byte_mask, mem_store_data,
      input  mem_ready, mem_load_data
   );

   modport slave (
      input  mem_valid, mem_address, mem_store, mem_byte_mask, mem_store_data,
      output mem_ready, mem_load_data
   );
endinterface

// File: rtl/mem_align.sv
// -----------------------------------------------------------------------------
// mem_align
// Combinational byte-lane logic for the memory stage.
//   size        access size (00 byte, 01 half, 10/11 word)
//   addr_lo     low two address bits
//   load_signed sign-extend the selected load lane
//   store_data  rs2 value
//   load_word   raw word returned by the bus
//   byte_mask   active byte lanes
//   store_lanes store data replicated across all lanes
//   load_data   selected, extended load result
// -----------------------------------------------------------------------------
module mem_align
   import memory_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        load_signed,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  byte_mask,
   output logic [31:0] store_lanes,
   output logic [31:0] load_data
);

   logic [31:0] shifted;

   // Bring the addressed lane down to bit 0
   assign shifted = load_word >> {addr_lo, 3'b000};

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // one unassigned -- that is what keeps this block free of latches.
      byte_mask   = 4'b1111;
      store_lanes = store_data;
      load_data   = shifted;
      case (size)
         SIZE_BYTE: begin
            byte_mask   = 4'b0001 << addr_lo;
            store_lanes = {4{store_data[7:0]}};
            load_data   = {{24{load_signed & shifted[7]}}, shifted[7:0]};
         end
         SIZE_HALF: begin
            byte_mask   = 4'b0011 << {addr_lo[1], 1'b0};
            store_lanes = {2{store_data[15:0]}};
            load_data   = {{16{load_signed & shifted[15]}}, shifted[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/memory.sv
// -----------------------------------------------------------------------------
// memory
// Memory-access stage of the in-order RV32 core (execute -> writeback).
// Issues loads/stores on the data bus, stalls upstream while a transfer is
// outstanding, formats load data, flags misaligned accesses, and registers
// everything writeback consumes. A flush never abandons an in-flight transfer:
// the stage drains it and discards the result.
//   clk, reset (sync, active-low)
//   *_in / load / store / size / load_signed / store_data : from execute
//   flush : trap taken by writeback this cycle
//   stall : upstream must hold its registers
//   bus   : data bus master
//   pc ... ecause : registered outputs to writeback
// -----------------------------------------------------------------------------
module memory
   import memory_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_in,
   input  logic [31:0] next_pc_in,
   input  logic [31:0] alu_data_in,
   input  logic [31:0] csr_data_in,
   input  logic [31:0] store_data,
   input  logic        load,
   input  logic        store,
   input  logic [1:0]  size,
   input  logic        load_signed,
   input  logic [1:0]  write_select_in,
   input  logic [4:0]  rd_addr_in,
   input  logic [11:0] csr_addr_in,
   input  logic        mret_in,
   input  logic        wfi_in,
   input  logic        valid_in,
   input  logic        exception_in,
   input  logic [3:0]  ecause_in,
   input  logic        flush,
   output logic        stall,
   memory_if.master    bus,
   output logic [31:0] pc,
   output logic [31:0] next_pc,
   output logic [31:0] alu_data,
   output logic [31:0] csr_data,
   output logic [31:0] load_data,
   output logic [1:0]  write_select,
   output logic [4:0]  rd_addr,
   output logic [11:0] csr_addr,
   output logic        mret,
   output logic        wfi,
   output logic        valid,
   output logic        exception,
   output logic [3:0]  ecause
);

   state_t      state_q, state_d;
   wb_t         wb_q, wb_d, pass, bubble;
   logic        request, misaligned;
   logic        issue, retire;
   logic [3:0]  byte_mask;
   logic [31:0] store_lanes, load_fmt;

   assign request    = valid_in && (load || store) && !exception_in;
   assign misaligned = is_misaligned(size, alu_data_in[1:0]);

   // Upstream holds its registers while BUSY, so the current inputs still
   // describe the outstanding access when mem_ready arrives.
   mem_align u_align (
      .size        (size),
      .addr_lo     (alu_data_in[1:0]),
      .load_signed (load_signed),
      .store_data  (store_data),
      .load_word   (bus.mem_load_data),
      .byte_mask   (byte_mask),
      .store_lanes (store_lanes),
      .load_data   (load_fmt)
   );

   // Incoming instruction as it would leave this stage unmodified
   always_comb begin
      pass.pc           = pc_in;
      pass.next_pc      = next_pc_in;
      pass.alu_data     = alu_data_in;
      pass.csr_data     = csr_data_in;
      pass.load_data    = 32'h0;
      pass.write_select = write_select_in;
      pass.rd_addr      = rd_addr_in;
      pass.csr_addr     = csr_addr_in;
      pass.mret         = mret_in;
      pass.wfi          = wfi_in;
      pass.valid        = valid_in;
      pass.exception    = exception_in;
      pass.ecause       = ecause_in;

      bubble           = pass;
      bubble.valid     = 1'b0;
      bubble.exception = 1'b0;
      bubble.rd_addr   = 5'd0;
   end

   // Next-state, stall and write-back selection
   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      issue   = 1'b0;
      retire  = 1'b0;
      wb_d    = bubble;
      case (state_q)
         ST_IDLE: begin
            if (flush) begin
               wb_d = bubble;
            end else if (request && misaligned) begin
               wb_d           = pass;
               wb_d.exception = 1'b1;
               wb_d.ecause    = store ? ECAUSE_STORE_MISALIGNED : ECAUSE_LOAD_MISALIGNED;
            end else if (request) begin
               issue   = 1'b1;
               stall   = 1'b1;
               state_d = ST_BUSY;
            end else begin
               wb_d = pass;
            end
         end
         ST_BUSY: begin
            stall = !bus.mem_ready && !flush;
            if (bus.mem_ready) begin
               retire  = 1'b1;
               state_d = ST_IDLE;
               if (!flush) begin
                  wb_d           = pass;
                  wb_d.load_data = load ? load_fmt : 32'h0;
               end
            end else if (flush) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // The bus still owes us a response; hold any new access back
            stall = !bus.mem_ready && request;
            if (bus.mem_ready) begin
               retire  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state is assigned with <= so every register samples
      // values from before this edge, independent of statement order.
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Bus request registers: loaded on issue, frozen until mem_ready
   always_ff @(posedge clk) begin
      if (!reset) begin
         bus.mem_valid      <= 1'b0;
         bus.mem_store      <= 1'b0;
         bus.mem_address    <= 32'h0;
         bus.mem_byte_mask  <= 4'h0;
         bus.mem_store_data <= 32'h0;
      end else if (issue) begin
         bus.mem_valid      <= 1'b1;
         bus.mem_store      <= store;
         bus.mem_address    <= {alu_data_in[31:2], 2'b00};
         bus.mem_byte_mask  <= byte_mask;
         bus.mem_store_data <= store_lanes;
      end else if (retire) begin
         bus.mem_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) wb_q <= '0;
      else        wb_q <= wb_d;
   end

   assign pc           = wb_q.pc;
   assign next_pc      = wb_q.next_pc;
   assign alu_data     = wb_q.alu_data;
   assign csr_data     = wb_q.csr_data;
   assign load_data    = wb_q.load_data;
   assign write_select = wb_q.write_select;
   assign rd_addr      = wb_q.rd_addr;
   assign csr_addr     = wb_q.csr_addr;
   assign mret         = wb_q.mret;
   assign wfi          = wb_q.wfi;
   assign valid        = wb_q.valid;
   assign exception    = wb_q.exception;
   assign ecause       = wb_q.ecause;

endmodule
